teclado_escaner: RTL
====================

# teclado_escaner

Scanner for a 4x4 matrix keypad, the input-side counterpart of the multiplexed 7-segment display driver. It drives one column low at a time, samples the row lines, debounces the result over whole scans, and emits a 4-bit key code with a single-cycle valid strobe. The board uses it for operator entry of the current and frequency setpoints shown on the display.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each column stays driven; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock; the block has one clock.
- rst  input  1  synchronous, active-high reset.
- filas  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- columnas  output  4  column drive, active-low one-hot; exactly one bit is low at all times.
- tecla  output  4  code of the last accepted key; holds its value until the next accept.
- tecla_valida  output  1  one-cycle pulse when a new key is accepted.
- tecla_presionada  output  1  high from accept until the release is accepted.

## Operation
- filas passes through a 2-flop synchronizer before use.
- The column index counts 0→1→2→3→0. Each step lasts SCAN_DIV cycles.
- Rows are sampled on the last cycle of each column slot.
- One scan is 4 slots. At the end of each scan, the combined 16-bit sample classifies as:
  - VACIO: no key pressed.
  - UNICA(k): exactly one key pressed, k is its code.
  - MULTIPLE: two or more keys pressed.
- Keymap, by row and column:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Codes: digits map to 0x0–0x9; A–D map to 0xA–0xD; * maps to 0xE; # maps to 0xF.
- The debounce FSM evaluates once per scan end:
  - REPOSO: UNICA(k) latches candidate k, sets cnt=1 and goes to CANDIDATO. Anything else stays.
  - CANDIDATO:
    - UNICA(same k): cnt++. When cnt reaches DEBOUNCE_SCANS, load tecla=k, pulse tecla_valida, go to PRESIONADA.
    - UNICA(other k'): candidate becomes k', cnt=1.
    - VACIO or MULTIPLE: go to REPOSO.
  - PRESIONADA: VACIO sets cnt=1 and goes to LIBERANDO. UNICA or MULTIPLE of any key stays; a key change without release is never accepted.
  - LIBERANDO:
    - VACIO: cnt++. When cnt reaches DEBOUNCE_SCANS, go to REPOSO and clear tecla_presionada.
    - UNICA or MULTIPLE: go back to PRESIONADA.
- tecla_presionada is high exactly in PRESIONADA and LIBERANDO.

## Timing
- Reset values:
  - columnas=4'b1110
  - tecla=4'h0
  - tecla_valida=0
  - tecla_presionada=0
  - FSM in REPOSO
  - scan counters at 0
  - synchronizer flops at 4'b1111
- A reset mid-scan or mid-press restarts everything from the reset state. A key still held afterwards is re-debounced and re-reported.
- columnas changes on the clock edge after the last cycle of each slot.
- The first column change after reset happens at cycle SCAN_DIV.
- tecla and tecla_valida update on the same edge: the edge after the scan-end cycle of the DEBOUNCE_SCANS-th matching scan.
- Accept latency from a clean press: at most (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 cycles.
- tecla_valida is never high on two consecutive cycles. There is at most one pulse per press/release cycle.
- Counter widths: slot counter is $clog2(SCAN_DIV); cnt is $clog2(DEBOUNCE_SCANS+1). Neither counter wraps inside its state.

## Structure
- Package teclado_pkg holds:
  - key code localparams (TECLA_0…TECLA_F);
  - the FSM state enum (REPOSO, CANDIDATO, PRESIONADA, LIBERANDO);
  - the scan-class enum (VACIO, UNICA, MULTIPLE);
  - a function mapping (fila, columna) to code.
- Sub-module barrido_columnas contains the slot divider and the 2-bit column counter. It outputs the column index, the sample-enable strobe and the scan-end strobe.
- The top level contains the synchronizer, the classifier and the FSM.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
- Reset: columnas=1110 and all outputs 0. columnas=1101 at cycle 4 and back to 1110 at cycle 16.
- Clean press of '5' (row1 low while col1 driven), held 100 cycles → one tecla_valida pulse with tecla=0x5, within 67 cycles of press. tecla_presionada falls 3–4 scans after release.
- '8' bouncing (row toggled every 5 cycles for 40 cycles, then stable) → exactly one pulse with tecla=0x8.
- '1' and '2' held simultaneously for 200 cycles → no pulse; tecla_presionada stays 0.
- Hold '#' (pulse, tecla=0xF), then switch to '0' without a gap → no pulse. Release for 64 cycles, then press '0' → pulse with tecla=0x0.
- rst asserted for 1 cycle while 'D' is held in PRESIONADA → outputs clear next cycle and columnas=1110. With 'D' still held, a new pulse with tecla=0xD follows.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, FSM states,
// scan classification and the (row, column) to key-code map.
package teclado_pkg;

   localparam logic [3:0] TECLA_0 = 4'h0;
   localparam logic [3:0] TECLA_1 = 4'h1;
   localparam logic [3:0] TECLA_2 = 4'h2;
   localparam logic [3:0] TECLA_3 = 4'h3;
   localparam logic [3:0] TECLA_4 = 4'h4;
   localparam logic [3:0] TECLA_5 = 4'h5;
   localparam logic [3:0] TECLA_6 = 4'h6;
   localparam logic [3:0] TECLA_7 = 4'h7;
   localparam logic [3:0] TECLA_8 = 4'h8;
   localparam logic [3:0] TECLA_9 = 4'h9;
   localparam logic [3:0] TECLA_A = 4'hA;
   localparam logic [3:0] TECLA_B = 4'hB;
   localparam logic [3:0] TECLA_C = 4'hC;
   localparam logic [3:0] TECLA_D = 4'hD;
   localparam logic [3:0] TECLA_E = 4'hE;
   localparam logic [3:0] TECLA_F = 4'hF;

   typedef enum logic [1:0] {
      REPOSO,
      CANDIDATO,
      PRESIONADA,
      LIBERANDO
   } estado_t;

   typedef enum logic [1:0] {
      VACIO,
      UNICA,
      MULTIPLE
   } clase_t;

   // '*' is reported as 0xE and '#' as 0xF.
   function automatic logic [3:0] codigo_tecla(input logic [1:0] fila,
                                               input logic [1:0] columna);
      logic [3:0] w_cod;
      case ({fila, columna})
         4'b00_00: w_cod = TECLA_1;
         4'b00_01: w_cod = TECLA_2;
         4'b00_10: w_cod = TECLA_3;
         4'b00_11: w_cod = TECLA_A;
         4'b01_00: w_cod = TECLA_4;
         4'b01_01: w_cod = TECLA_5;
         4'b01_10: w_cod = TECLA_6;
         4'b01_11: w_cod = TECLA_B;
         4'b10_00: w_cod = TECLA_7;
         4'b10_01: w_cod = TECLA_8;
         4'b10_10: w_cod = TECLA_9;
         4'b10_11: w_cod = TECLA_C;
         4'b11_00: w_cod = TECLA_E;
         4'b11_01: w_cod = TECLA_0;
         4'b11_10: w_cod = TECLA_F;
         default:  w_cod = TECLA_D;
      endcase
      return w_cod;
   endfunction

endpackage

// File: rtl/barrido_columnas.sv
// Column-slot timing: a SCAN_DIV divider stepping a 2-bit column index,
// with strobes on the last cycle of each slot and of each full scan.
module barrido_columnas #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] o_columna,
   output logic       o_muestra,
   output logic       o_fin_scan
);

   localparam int            DW      = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_ULT = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIV_UNO = DW'(1);

   logic [DW-1:0] r_div;
   logic [1:0]    r_col;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
         r_col <= 2'd0;
      end else if (r_div == DIV_ULT) begin
         r_div <= '0;
         r_col <= r_col + 2'd1;
      end else begin
         r_div <= r_div + DIV_UNO;
      end
   end

   assign o_columna  = r_col;
   assign o_muestra  = (r_div == DIV_ULT);
   assign o_fin_scan = o_muestra && (r_col == 2'd3);

endmodule

// File: rtl/teclado_escaner.sv
// 4x4 matrix keypad scanner: row synchronizer, per-scan classifier and a
// debounce FSM that reports each accepted key with a one-cycle strobe.
module teclado_escaner
   import teclado_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] tecla,
   output logic       tecla_valida,
   output logic       tecla_presionada
);

   localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_UNO = CW'(1);
   localparam logic [CW-1:0] CNT_ULT = CW'(DEBOUNCE_SCANS - 1);

   logic [1:0]    w_columna;
   logic          w_muestra;
   logic          w_fin_scan;
   logic [15:0]   w_imagen;
   logic [3:0]    w_codigo;
   clase_t        w_clase;

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_columnas;
   logic [11:0]   r_parcial;
   estado_t       r_estado;
   logic [3:0]    r_cand;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_tecla;
   logic          r_valida;
   logic          r_presionada;

   barrido_columnas #(
      .SCAN_DIV (SCAN_DIV)
   ) u_barrido (
      .clk        (clk),
      .rst        (rst),
      .o_columna  (w_columna),
      .o_muestra  (w_muestra),
      .o_fin_scan (w_fin_scan)
   );

   // Rows idle high, so the synchronizer resets to "no key".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= filas;
         r_sync2 <= r_sync1;
      end
   end

   // Columns 0..2 are held here; column 3 is used live on the scan-end cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_columnas <= 4'b1110;
         r_parcial  <= '0;
      end else if (w_muestra) begin
         r_columnas <= {r_columnas[2:0], r_columnas[3]};
         case (w_columna)
            2'd0:    r_parcial[3:0]  <= ~r_sync2;
            2'd1:    r_parcial[7:4]  <= ~r_sync2;
            2'd2:    r_parcial[11:8] <= ~r_sync2;
            default: ;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_imagen = {~r_sync2, r_parcial};
      w_codigo = TECLA_0;
      for (int i = 0; i < 16; i++) begin
         if (w_imagen[i]) w_codigo = codigo_tecla(2'(i % 4), 2'(i / 4));
      end
      if (w_imagen == '0)
         w_clase = VACIO;
      else if ((w_imagen & (w_imagen - 16'd1)) == '0)
         w_clase = UNICA;
      else
         w_clase = MULTIPLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado     <= REPOSO;
         r_cand       <= TECLA_0;
         r_cnt        <= '0;
         r_tecla      <= TECLA_0;
         r_valida     <= 1'b0;
         r_presionada <= 1'b0;
      end else begin
         r_valida <= 1'b0;
         if (w_fin_scan) begin
            unique case (r_estado)
               REPOSO: begin
                  if (w_clase == UNICA) begin
                     r_cand   <= w_codigo;
                     r_cnt    <= CNT_UNO;
                     r_estado <= CANDIDATO;
                  end
               end
               CANDIDATO: begin
                  if (w_clase != UNICA) begin
                     r_estado <= REPOSO;
                  end else if (w_codigo != r_cand) begin
                     r_cand <= w_codigo;
                     r_cnt  <= CNT_UNO;
                  end else if (r_cnt == CNT_ULT) begin
                     r_tecla      <= r_cand;
                     r_valida     <= 1'b1;
                     r_presionada <= 1'b1;
                     r_estado     <= PRESIONADA;
                  end else begin
                     r_cnt <= r_cnt + CNT_UNO;
                  end
               end
               // A different key without an intervening release is ignored.
               PRESIONADA: begin
                  if (w_clase == VACIO) begin
                     r_cnt    <= CNT_UNO;
                     r_estado <= LIBERANDO;
                  end
               end
               LIBERANDO: begin
                  if (w_clase != VACIO) begin
                     r_estado <= PRESIONADA;
                  end else if (r_cnt == CNT_ULT) begin
                     r_presionada <= 1'b0;
                     r_estado     <= REPOSO;
                  end else begin
                     r_cnt <= r_cnt + CNT_UNO;
                  end
               end
               default: r_estado <= REPOSO;
            endcase
         end
      end
   end

   assign columnas         = r_columnas;
   assign tecla            = r_tecla;
   assign tecla_valida     = r_valida;
   assign tecla_presionada = r_presionada;

endmodule
